// File: rtl/servo_telemetry_uart_tx.sv
// 8N1 UART transmitter sending HEADER, pos_a, pos_b (and an 8-bit sum CHK) per accepted sample.
// Build option: define TX_CHECKSUM_EN to append the CHK byte (4-byte packets instead of 3).
module servo_telemetry_uart_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter logic [7:0]  HEADER    = 8'hAA
) (
    input  logic       clk50mhz,
    input  logic       rst_n,
    input  logic       sample_valid,
    output logic       sample_ready,
    input  logic [7:0] pos_a,
    input  logic [7:0] pos_b,
    output logic       uart_tx,
    output logic       busy,
    output logic       pkt_done
);

    localparam int unsigned BAUD_TICK = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W     = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BAUD_TICK - 1);
    localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(BAUD_TICK - 2);
`ifdef TX_CHECKSUM_EN
    localparam int unsigned N_BYTES = 4;
`else
    localparam int unsigned N_BYTES = 3;
`endif
    localparam logic [1:0] LAST_BYTE = 2'(N_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_byte_idx;
    logic             r_tx;
    logic             r_done;
    logic [7:0]       r_pos_a;
    logic [7:0]       r_pos_b;
    logic [7:0]       w_cur_byte;
    logic [2:0]       w_next_bit_idx;
    logic             w_bit_end;

    assign w_bit_end      = (r_baud_cnt == TICK_LAST);
    assign w_next_bit_idx = r_bit_idx + 3'd1;

    // Sample payload carries no reset: it is only read after an accepting edge.
    always_ff @(posedge clk50mhz) begin
        if (r_state == S_IDLE && sample_valid) begin
            r_pos_a <= pos_a;
            r_pos_b <= pos_b;
        end
    end

`ifdef TX_CHECKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge clk50mhz) begin
        if (r_state == S_START && r_byte_idx == 2'd0) begin
            r_chk <= HEADER + r_pos_a + r_pos_b;
        end
    end
`endif

    always_comb begin
        w_cur_byte = HEADER;
        case (r_byte_idx)
            2'd1:    w_cur_byte = r_pos_a;
            2'd2:    w_cur_byte = r_pos_b;
`ifdef TX_CHECKSUM_EN
            2'd3:    w_cur_byte = r_chk;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (sample_valid) begin
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                        r_baud_cnt <= '0;
                        r_byte_idx <= 2'd0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_tx       <= w_cur_byte[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= w_next_bit_idx;
                            r_tx      <= w_cur_byte[w_next_bit_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Raised one clock early so the registered pulse lands on the last stop clock.
                    if (r_byte_idx == LAST_BYTE && r_baud_cnt == TICK_PRE) begin
                        r_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx == LAST_BYTE) begin
                            r_byte_idx <= 2'd0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign uart_tx      = r_tx;
    assign sample_ready = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign pkt_done     = r_done;

endmodule

// File: tb/tb_servo_telemetry_uart_tx.sv
// Bench for servo_telemetry_uart_tx: waveform-queue reference model plus table-driven packet decoding.
// Honours TX_CHECKSUM_EN the same way the design does.
module tb_servo_telemetry_uart_tx;

    localparam int CLKF  = 20;
    localparam int BAUDR = 2;
    localparam int TCK   = CLKF / BAUDR;
`ifdef TX_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int PKT = NB * 10 * TCK;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] pos_a = 8'h00;
    logic [7:0] pos_b = 8'h00;
    logic       sample_ready;
    logic       uart_tx;
    logic       busy;
    logic       pkt_done;

    servo_telemetry_uart_tx #(
        .CLK_FREQ (CLKF),
        .BAUD_RATE(BAUDR),
        .HEADER   (8'hAA)
    ) dut (
        .clk50mhz    (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .pos_a       (pos_a),
        .pos_b       (pos_b),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .pkt_done    (pkt_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit line_log [0:65535];
    int done_q[$];
    int acc_q[$];
    bit exp_q[$];
    bit m_active = 1'b0;
    bit e_tx = 1'b1;
    bit e_ready = 1'b1;
    bit e_done = 1'b0;
    int wave_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] chk;
    } vec_t;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Reference: an accepted sample becomes the full per-clock line waveform of its packet.
    task automatic model_edge();
        logic [7:0] pk [4];
        int sum;
        if (!rst_n) begin
            exp_q.delete();
            m_active = 1'b0;
            e_tx = 1'b1;
        end else if (m_active) begin
            if (exp_q.size() > 0) e_tx = exp_q.pop_front();
            else begin
                m_active = 1'b0;
                e_tx = 1'b1;
            end
        end else if (sample_valid) begin
            sum = 'hAA + int'(pos_a) + int'(pos_b);
            pk[0] = 8'hAA;
            pk[1] = pos_a;
            pk[2] = pos_b;
            pk[3] = sum[7:0];
            for (int j = 0; j < NB; j++) begin
                repeat (TCK) exp_q.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (TCK) exp_q.push_back(pk[j][i]);
                repeat (TCK) exp_q.push_back(1'b1);
            end
            m_active = 1'b1;
            acc_q.push_back(cyc);
            e_tx = exp_q.pop_front();
        end else begin
            e_tx = 1'b1;
        end
        e_done  = m_active && (exp_q.size() == 0);
        e_ready = !m_active;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc < 65536) line_log[cyc] = uart_tx;
        if (pkt_done) done_q.push_back(cyc);
        if (uart_tx !== e_tx || sample_ready !== e_ready || busy !== !e_ready || pkt_done !== e_done)
            wave_err++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        pos_a = a;
        pos_b = b;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int k;
        n = done_q.size();
        k = 0;
        while (done_q.size() == n && k < budget) begin
            step();
            k++;
        end
        check({name, "_done_seen"}, int'(done_q.size() > n), 1);
    endtask

    function automatic logic [7:0] decode(input int start, input int j, output bit ok);
        int base;
        logic [7:0] v;
        base = start + j * 10 * TCK + TCK / 2;
        for (int i = 0; i < 8; i++) v[i] = line_log[base + (i + 1) * TCK];
        ok = (line_log[base] == 1'b0) && (line_log[base + 9 * TCK] == 1'b1);
        return v;
    endfunction

    task automatic check_packet(input string name, input int acc, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] chk);
        logic [7:0] expb [4];
        logic [7:0] got;
        bit ok;
        expb[0] = 8'hAA;
        expb[1] = a;
        expb[2] = b;
        expb[3] = chk;
        for (int j = 0; j < NB; j++) begin
            got = decode(acc + 1, j, ok);
            check($sformatf("%s_byte%0d", name, j), int'(got), int'(expb[j]));
            check($sformatf("%s_frame%0d", name, j), int'(ok), 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt [5];
        int zeros;
        int nd;
        int na;
        int a1;
        int d1;

        vt[0] = '{8'h80, 8'h7F, 8'hA9};
        vt[1] = '{8'hFF, 8'hFF, 8'hA8};
        vt[2] = '{8'h00, 8'hFF, 8'hA9};
        vt[3] = '{8'h10, 8'h20, 8'hDA};
        vt[4] = '{8'h12, 8'h34, 8'hF0};

        // Reset and idle line
        repeat (10) step();
        rst_n = 1'b1;
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_ready", int'(sample_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        zeros = 0;
        repeat (20000) begin
            step();
            if (uart_tx !== 1'b1) zeros++;
        end
        check("idle_line_low_cycles", zeros, 0);
        check("wave_reset", wave_err, 0);
        wave_err = 0;

        // Table-driven single packets
        for (int v = 0; v < 5; v++) begin
            send(vt[v].a, vt[v].b);
            wait_done($sformatf("vec%0d", v), PKT + 20);
            check_packet($sformatf("vec%0d", v), acc_q[$], vt[v].a, vt[v].b, vt[v].chk);
            check($sformatf("vec%0d_latency", v), done_q[$] - acc_q[$], PKT);
            repeat (3) step();
            check($sformatf("vec%0d_tx_after", v), int'(uart_tx), 1);
            check($sformatf("vec%0d_ready_after", v), int'(sample_ready), 1);
        end
        check("wave_table", wave_err, 0);
        wave_err = 0;

        // Busy hold-off with valid held high
        pos_a = 8'h10;
        pos_b = 8'h20;
        sample_valid = 1'b1;
        step();
        pos_a = 8'h55;
        pos_b = 8'h66;
        wait_done("hold1", PKT + 20);
        d1 = done_q[$];
        a1 = acc_q[$];
        wait_done("hold2", PKT + 20);
        sample_valid = 1'b0;
        repeat (3) step();
        check("hold_accepts", int'(acc_q[$] != a1), 1);
        check_packet("hold1", a1, 8'h10, 8'h20, 8'hDA);
        check_packet("hold2", acc_q[$], 8'h55, 8'h66, 8'h65);
        check("hold_period", acc_q[$] - a1, PKT + 1);
        check("hold_idle_gap", int'(line_log[d1 + 1]), 1);
        check("hold_next_start", int'(line_log[d1 + 2]), 0);
        check("wave_hold", wave_err, 0);
        wave_err = 0;

        // Reset in the middle of pos_a data bits
        send(8'hC3, 8'h3C);
        repeat (14 * TCK + TCK / 2) step();
        check("pre_reset_line", int'(uart_tx), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", int'(uart_tx), 1);
        check("async_rst_ready", int'(sample_ready), 1);
        check("async_rst_busy", int'(busy), 0);
        repeat (5) step();
        rst_n = 1'b1;
        nd = done_q.size();
        zeros = 0;
        repeat (2 * PKT) begin
            step();
            if (uart_tx !== 1'b1) zeros++;
        end
        check("post_rst_low_cycles", zeros, 0);
        check("post_rst_no_done", done_q.size() - nd, 0);
        send(8'h12, 8'h34);
        wait_done("post_rst_pkt", PKT + 20);
        check_packet("post_rst_pkt", acc_q[$], 8'h12, 8'h34, 8'hF0);
        repeat (3) step();
        check("wave_midreset", wave_err, 0);
        wave_err = 0;

        // Randomised traffic, inputs change every cycle including while busy
        nd = done_q.size();
        na = acc_q.size();
        repeat (3000) begin
            pos_a = 8'($urandom);
            pos_b = 8'($urandom);
            sample_valid = ($urandom_range(0, 7) == 0);
            step();
        end
        sample_valid = 1'b0;
        repeat (PKT + 10) step();
        check("rand_packets_done", done_q.size() - nd, acc_q.size() - na);
        check("rand_some_packets", int'(acc_q.size() - na > 2), 1);
        check("wave_random", wave_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
